tx_req_arbiter: RTL and testbench

- Shares the single TX engine between two header-request sources.
  - Requester 0 (CPL): completion requests from the command-process FSM.
  - Requester 1 (MWR): upstream memory-write requests from the DMA path.
- Grants one requester at a time and latches its header.
- Drives a single request/done handshake to the TX engine.
- Returns a one-cycle done pulse to the winning requester.
- Includes a watchdog so a hung TX engine cannot lock out both sources.

---
 rtl/tx_req_arbiter.sv | 140 ++++++++++++++
 tb/tb_tx_req_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_req_arbiter.sv
// tx_req_arbiter: round-robin arbiter sharing one TX engine between the
// completion (CPL) and upstream memory-write (MWR) header requesters, with a
// watchdog that aborts a transaction if the TX engine never reports done.
module tx_req_arbiter #(
  parameter int unsigned HDR_W       = 96,
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpl_req_i,
  input  logic             cpl_with_data_i,
  input  logic [HDR_W-1:0] cpl_hdr_i,
  output logic             cpl_done_o,
  input  logic             mwr_req_i,
  input  logic [HDR_W-1:0] mwr_hdr_i,
  output logic             mwr_done_o,
  output logic             tx_req_o,
  output logic [1:0]       tx_type_o,
  output logic [HDR_W-1:0] tx_hdr_o,
  input  logic             tx_done_i,
  output logic             busy_o,
  output logic             timeout_err_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

  localparam logic GNT_CPL = 1'b0;
  localparam logic GNT_MWR = 1'b1;

  localparam logic [1:0] TYPE_CPL  = 2'b00;
  localparam logic [1:0] TYPE_CPLD = 2'b01;
  localparam logic [1:0] TYPE_MWR  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_last_grant;
  logic [CNT_W-1:0] r_cnt;
  logic [HDR_W-1:0] r_hdr;
  logic [1:0]       r_type;
  logic             r_timeout_err;

  logic             w_any_req;
  logic             w_grant_sel;
  logic             w_take;
  logic             w_expire;

  // Pick the winner among active requests; on a tie, the one not served last.
  always_comb begin
    w_any_req   = cpl_req_i | mwr_req_i;
    w_grant_sel = GNT_CPL;
    if (cpl_req_i && mwr_req_i) begin
      w_grant_sel = ~r_last_grant;
    end else if (mwr_req_i) begin
      w_grant_sel = GNT_MWR;
    end
  end

  assign w_take   = (r_state == S_IDLE) && w_any_req;
  // Done on the same cycle as the limit wins over the watchdog.
  assign w_expire = (r_state == S_ISSUE) && !tx_done_i && (r_cnt == CNT_MAX);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req) w_state_nxt = S_ISSUE;
      S_ISSUE: if (tx_done_i || w_expire) w_state_nxt = S_GAP;
      S_GAP:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from the state register; the done pulse is the GAP cycle.
  always_comb begin
    tx_req_o      = 1'b0;
    cpl_done_o    = 1'b0;
    mwr_done_o    = 1'b0;
    busy_o        = 1'b0;
    tx_type_o     = r_type;
    tx_hdr_o      = r_hdr;
    timeout_err_o = r_timeout_err;
    case (r_state)
      S_ISSUE: begin
        tx_req_o = 1'b1;
        busy_o   = 1'b1;
      end
      S_GAP: begin
        busy_o     = 1'b1;
        cpl_done_o = (r_last_grant == GNT_CPL);
        mwr_done_o = (r_last_grant == GNT_MWR);
      end
      default: ;
    endcase
  end

  // Grant bookkeeping: latch header/type on grant, run the saturating watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant  <= GNT_MWR;
      r_cnt         <= '0;
      r_hdr         <= '0;
      r_type        <= TYPE_CPL;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_take) begin
        r_last_grant <= w_grant_sel;
        r_cnt        <= '0;
        if (w_grant_sel == GNT_CPL) begin
          r_hdr  <= cpl_hdr_i;
          r_type <= cpl_with_data_i ? TYPE_CPLD : TYPE_CPL;
        end else begin
          r_hdr  <= mwr_hdr_i;
          r_type <= TYPE_MWR;
        end
      end else if ((r_state == S_ISSUE) && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_expire) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tx_req_arbiter.sv
// Bench for tx_req_arbiter: table of per-cycle vectors plus hand-written
// sequences for the watchdog boundary, asynchronous reset and watchdog expiry.
module tb_tx_req_arbiter;

  localparam int unsigned HDR_W = 96;
  localparam int unsigned TMO   = 1023;

  localparam logic [HDR_W-1:0] H0   = '0;
  localparam logic [HDR_W-1:0] HC   = {12{8'hA5}};
  localparam logic [HDR_W-1:0] HM   = {12{8'h3C}};
  localparam logic [HDR_W-1:0] JNKC = {12{8'hDE}};
  localparam logic [HDR_W-1:0] JNKM = {12{8'h71}};

  logic             clk;
  logic             rst_n;
  logic             cpl_req_i;
  logic             cpl_with_data_i;
  logic [HDR_W-1:0] cpl_hdr_i;
  logic             cpl_done_o;
  logic             mwr_req_i;
  logic [HDR_W-1:0] mwr_hdr_i;
  logic             mwr_done_o;
  logic             tx_req_o;
  logic [1:0]       tx_type_o;
  logic [HDR_W-1:0] tx_hdr_o;
  logic             tx_done_i;
  logic             busy_o;
  logic             timeout_err_o;

  int total;
  int bad;

  tx_req_arbiter #(.HDR_W(HDR_W), .TIMEOUT_CYC(TMO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cpl_req_i      (cpl_req_i),
    .cpl_with_data_i(cpl_with_data_i),
    .cpl_hdr_i      (cpl_hdr_i),
    .cpl_done_o     (cpl_done_o),
    .mwr_req_i      (mwr_req_i),
    .mwr_hdr_i      (mwr_hdr_i),
    .mwr_done_o     (mwr_done_o),
    .tx_req_o       (tx_req_o),
    .tx_type_o      (tx_type_o),
    .tx_hdr_o       (tx_hdr_o),
    .tx_done_i      (tx_done_i),
    .busy_o         (busy_o),
    .timeout_err_o  (timeout_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "bench time limit");
  end

  typedef struct {
    logic             rst;
    logic             cr;
    logic             cwd;
    logic             mr;
    logic             td;
    logic             e_req;
    logic [1:0]       e_type;
    logic [HDR_W-1:0] e_hdr;
    logic             e_cd;
    logic             e_md;
    logic             e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic cr, logic cwd, logic mr, logic td,
                              logic e_req, logic [1:0] e_type, logic [HDR_W-1:0] e_hdr,
                              logic e_cd, logic e_md, logic e_busy);
    vec_t v;
    v.rst = rst; v.cr = cr; v.cwd = cwd; v.mr = mr; v.td = td;
    v.e_req = e_req; v.e_type = e_type; v.e_hdr = e_hdr;
    v.e_cd = e_cd; v.e_md = e_md; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [HDR_W-1:0] act, input logic [HDR_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string p, input logic e_req, input logic [1:0] e_type,
                         input logic [HDR_W-1:0] e_hdr, input logic e_cd, input logic e_md,
                         input logic e_busy, input logic e_terr);
    chk({p, "_req"},  HDR_W'(tx_req_o),      HDR_W'(e_req));
    chk({p, "_type"}, HDR_W'(tx_type_o),     HDR_W'(e_type));
    chk({p, "_hdr"},  tx_hdr_o,              e_hdr);
    chk({p, "_cdn"},  HDR_W'(cpl_done_o),    HDR_W'(e_cd));
    chk({p, "_mdn"},  HDR_W'(mwr_done_o),    HDR_W'(e_md));
    chk({p, "_busy"}, HDR_W'(busy_o),        HDR_W'(e_busy));
    chk({p, "_terr"}, HDR_W'(timeout_err_o), HDR_W'(e_terr));
    chk({p, "_excl"}, HDR_W'(cpl_done_o & mwr_done_o), H0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cpl_req_i = 1'b0; cpl_with_data_i = 1'b0; mwr_req_i = 1'b0; tx_done_i = 1'b0;
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int drops;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    cpl_req_i = 1'b0; cpl_with_data_i = 1'b0; mwr_req_i = 1'b0; tx_done_i = 1'b0;
    cpl_hdr_i = HC; mwr_hdr_i = HM;
    #1;
    chk_all("rst", 1'b0, 2'b00, H0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();

    // CPL only with data, done 4 cycles after tx_req; then a stray done in IDLE
    vecs.push_back(mk(0, 1,1,0,0, 1,2'b01,HC, 0,0,1));
    vecs.push_back(mk(0, 1,1,0,0, 1,2'b01,HC, 0,0,1));
    vecs.push_back(mk(0, 1,1,0,0, 1,2'b01,HC, 0,0,1));
    vecs.push_back(mk(0, 1,1,0,0, 1,2'b01,HC, 0,0,1));
    vecs.push_back(mk(0, 1,1,0,1, 0,2'b01,HC, 1,0,1));
    vecs.push_back(mk(0, 0,0,0,0, 0,2'b01,HC, 0,0,0));
    vecs.push_back(mk(0, 0,0,0,1, 0,2'b01,HC, 0,0,0));
    vecs.push_back(mk(0, 0,0,0,0, 0,2'b01,HC, 0,0,0));
    // Both held after reset: CPL, MWR, CPL, MWR
    vecs.push_back(mk(1, 1,0,1,0, 1,2'b00,HC, 0,0,1));
    vecs.push_back(mk(0, 1,0,1,1, 0,2'b00,HC, 1,0,1));
    vecs.push_back(mk(0, 1,0,1,0, 0,2'b00,HC, 0,0,0));
    vecs.push_back(mk(0, 1,0,1,0, 1,2'b10,HM, 0,0,1));
    vecs.push_back(mk(0, 1,0,1,1, 0,2'b10,HM, 0,1,1));
    vecs.push_back(mk(0, 1,0,1,0, 0,2'b10,HM, 0,0,0));
    vecs.push_back(mk(0, 1,0,1,0, 1,2'b00,HC, 0,0,1));
    vecs.push_back(mk(0, 1,0,1,1, 0,2'b00,HC, 1,0,1));
    vecs.push_back(mk(0, 1,0,1,0, 0,2'b00,HC, 0,0,0));
    vecs.push_back(mk(0, 1,0,1,0, 1,2'b10,HM, 0,0,1));
    vecs.push_back(mk(0, 0,0,1,1, 0,2'b10,HM, 0,1,1));
    // Persistent MWR, CPL arrives mid-MWR and wins next
    vecs.push_back(mk(0, 0,0,1,0, 0,2'b10,HM, 0,0,0));
    vecs.push_back(mk(0, 0,0,1,0, 1,2'b10,HM, 0,0,1));
    vecs.push_back(mk(0, 1,1,1,0, 1,2'b10,HM, 0,0,1));
    vecs.push_back(mk(0, 1,1,1,1, 0,2'b10,HM, 0,1,1));
    vecs.push_back(mk(0, 1,1,1,0, 0,2'b10,HM, 0,0,0));
    vecs.push_back(mk(0, 1,1,1,0, 1,2'b01,HC, 0,0,1));
    vecs.push_back(mk(0, 1,1,1,1, 0,2'b01,HC, 1,0,1));
    vecs.push_back(mk(0, 0,0,1,0, 0,2'b01,HC, 0,0,0));
    // Request dropped mid-ISSUE still completes with a done pulse
    vecs.push_back(mk(0, 0,0,1,0, 1,2'b10,HM, 0,0,1));
    vecs.push_back(mk(0, 0,0,0,0, 1,2'b10,HM, 0,0,1));
    vecs.push_back(mk(0, 0,0,0,1, 0,2'b10,HM, 0,1,1));
    vecs.push_back(mk(0, 0,0,0,0, 0,2'b10,HM, 0,0,0));

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      cpl_req_i       = vecs[i].cr;
      cpl_with_data_i = vecs[i].cwd;
      mwr_req_i       = vecs[i].mr;
      tx_done_i       = vecs[i].td;
      cpl_hdr_i       = vecs[i].cr ? HC : JNKC;
      mwr_hdr_i       = vecs[i].mr ? HM : JNKM;
      step();
      chk_all($sformatf("v%0d", i), vecs[i].e_req, vecs[i].e_type, vecs[i].e_hdr,
              vecs[i].e_cd, vecs[i].e_md, vecs[i].e_busy, 1'b0);
    end
    cpl_req_i = 1'b0; mwr_req_i = 1'b0; tx_done_i = 1'b0;
    cpl_hdr_i = HC; mwr_hdr_i = HM;

    // Done on the exact cycle the counter reaches the limit: normal completion
    mwr_req_i = 1'b1;
    step();
    chk_all("bnd_go", 1'b1, 2'b10, HM, 1'b0, 1'b0, 1'b1, 1'b0);
    drops = 0;
    for (int k = 0; k < int'(TMO); k++) begin
      step();
      if (!tx_req_o || mwr_done_o) drops++;
    end
    chk("bnd_hold", HDR_W'(drops), H0);
    tx_done_i = 1'b1;
    step();
    tx_done_i = 1'b0; mwr_req_i = 1'b0;
    chk_all("bnd_done", 1'b0, 2'b10, HM, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    chk_all("bnd_idle", 1'b0, 2'b10, HM, 1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset while tx_req_o is high; pending CPL wins afterwards
    mwr_req_i = 1'b1;
    step();
    chk_all("ar_go", 1'b1, 2'b10, HM, 1'b0, 1'b0, 1'b1, 1'b0);
    cpl_req_i = 1'b1; cpl_with_data_i = 1'b0;
    step();
    #3;
    rst_n = 1'b0;
    #1;
    chk_all("ar_async", 1'b0, 2'b00, H0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk_all("ar_held", 1'b0, 2'b00, H0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_all("ar_cpl", 1'b1, 2'b00, HC, 1'b0, 1'b0, 1'b1, 1'b0);
    tx_done_i = 1'b1;
    step();
    tx_done_i = 1'b0; cpl_req_i = 1'b0;
    chk_all("ar_cdone", 1'b0, 2'b00, HC, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    step();
    chk_all("ar_mwr", 1'b1, 2'b10, HM, 1'b0, 1'b0, 1'b1, 1'b0);
    tx_done_i = 1'b1;
    step();
    tx_done_i = 1'b0; mwr_req_i = 1'b0;
    chk_all("ar_mdone", 1'b0, 2'b10, HM, 1'b0, 1'b1, 1'b1, 1'b0);
    step();

    // Watchdog expiry, then sticky error through a normal transaction
    mwr_req_i = 1'b1;
    step();
    chk_all("wd_go", 1'b1, 2'b10, HM, 1'b0, 1'b0, 1'b1, 1'b0);
    drops = 0;
    for (int k = 0; k < int'(TMO); k++) begin
      step();
      if (!tx_req_o || mwr_done_o || timeout_err_o) drops++;
    end
    chk("wd_hold", HDR_W'(drops), H0);
    step();
    mwr_req_i = 1'b0;
    chk_all("wd_abort", 1'b0, 2'b10, HM, 1'b0, 1'b1, 1'b1, 1'b1);
    step();
    chk_all("wd_idle", 1'b0, 2'b10, HM, 1'b0, 1'b0, 1'b0, 1'b1);
    cpl_req_i = 1'b1; cpl_with_data_i = 1'b1;
    step();
    chk_all("wd_cpl", 1'b1, 2'b01, HC, 1'b0, 1'b0, 1'b1, 1'b1);
    tx_done_i = 1'b1;
    step();
    tx_done_i = 1'b0; cpl_req_i = 1'b0;
    chk_all("wd_cdone", 1'b0, 2'b01, HC, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    step();
    chk_all("wd_end", 1'b0, 2'b01, HC, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
